usb_tx_arbiter: RTL and testbench
=================================

# usb_tx_arbiter

Round-robin packet arbiter for the upstream (FPGA→host) EP6 data path. It shares the EP6 FIFO write port between up to N_SRC packet sources and moves whole packets only, so packets from different sources never interleave. It enforces a maximum packet length and drains any over-length packet. It sits between the readout/status packet builders and the EP6 FIFO that the slave-FIFO engine empties on `FIFO_CLOCK`.

## Interface
- `N_SRC`, 4: number of sources, 2..8.
- `MAX_WORDS`, 1024: maximum words forwarded per packet, ≥2.
- `clk` in 1: FIFO clock, the same domain as the EP6 FIFO write side.
- `rst` in 1: synchronous, active-high reset.
- `src_req` in N_SRC: source i holds at least one complete packet.
- `src_empty` in N_SRC: source i FIFO empty.
- `src_data` in 16*N_SRC: first-word-fall-through head word; source i occupies bits [16i+15:16i].
- `src_last` in N_SRC: source i's head word is the last word of its packet.
- `src_re` out N_SRC: pops the head word of source i.
- `dst_data` out 16: word written to the EP6 FIFO.
- `dst_we` out 1: EP6 FIFO write enable.
- `dst_full` in 1: EP6 FIFO full.
- `grant` out N_SRC: one-hot owner of the path; all zero when idle.
- `busy` out 1: a packet is in progress.
- `pkt_done` out 1: one-cycle pulse after each packet ends.
- `trunc_err` out 1: one-cycle pulse when a packet exceeds MAX_WORDS.

## Operation
- States:
  - IDLE: no owner.
  - HDR: header word, only when the header feature is compiled in.
  - XFER: forwarding words.
  - DRAIN: discarding the tail of an over-length packet.
  - GAP: one-cycle end of packet.
- IDLE: if any `src_req` is high, select the first requester searching upward, modulo N_SRC, from `last_grant+1`. Then:
  - latch that source into `grant`;
  - clear the word counter;
  - go to HDR (header enabled) or XFER.
- XFER: a word moves in any cycle where `!dst_full && !src_empty[g]`. In that cycle:
  - `src_re[g]=1`, `dst_we=1`, `dst_data=src_data[g]`;
  - the word counter increments.
- XFER exits:
  - A word moved with `src_last[g]=1` → GAP.
  - A word moved that brings the counter to MAX_WORDS without `src_last` → DRAIN, with a `trunc_err` pulse in the following cycle.
- DRAIN: pops source g whenever `!src_empty[g]`, with `dst_we=0`, until a word with `src_last[g]` is popped → GAP. `dst_full` is ignored in this state.
- GAP:
  - `pkt_done=1` for one cycle;
  - `last_grant` ← g;
  - `grant` cleared;
  - next state IDLE.
- `busy` is high in HDR, XFER and DRAIN.
- `src_re` and `dst_we` never assert for non-granted sources, and never assert in IDLE or GAP.
- A `src_req` that deasserts after grant has no effect; the packet is completed.
- Word counter width is clog2(MAX_WORDS)+1 and saturates; it never wraps.
- Reset, including mid-packet:
  - state IDLE;
  - `grant`, `src_re`, `dst_we`, `busy`, `pkt_done`, `trunc_err` = 0;
  - `dst_data` = 0;
  - `last_grant` = N_SRC-1, so source 0 has first priority.
- A partially read source packet is not recovered after reset; the source resets with the arbiter.

## Timing
- `src_re`, `dst_we` and `dst_data` are combinational from the registered state, `grant`, `dst_full`, `src_empty` and `src_data`. This gives zero-latency pop-to-write with no skid buffer.
- `grant`, `busy`, `pkt_done` and `trunc_err` are registered.
- Latency:
  - `src_req` high in IDLE at edge k → `grant` valid after k, first write possible in cycle k+1 (k+2 with header).
  - Last word written in cycle t → `pkt_done` in t+1, IDLE in t+2, next packet's first write no earlier than t+3.
- `dst_full` high blocks the write in that same cycle; no word is lost or duplicated.

## Configuration
- `USB_TX_HDR_EN` defined:
  - HDR inserts one word {4'hC, 4'(g), 8'h00} before each packet, written when `!dst_full`;
  - no source pop occurs in that cycle;
  - the header is not counted toward MAX_WORDS.
- Not defined: HDR is absent and IDLE goes directly to XFER.

## Test plan
- Source 0 packet 0x1111, 0x2222, 0x3333 (last) with the others idle → three consecutive `dst_we` with those values, `grant`=0001, `pkt_done` one cycle after 0x3333.
- All four sources request 2-word packets from reset → grant order 0, 1, 2, 3, 0; 8 words per round with no interleaving.
- `dst_full` high for 5 cycles after the 2nd word of a 6-word packet → no `src_re`/`dst_we` for those cycles; all 6 words arrive in order exactly once.
- MAX_WORDS=8, 11-word packet from source 2 → 8 words written, `trunc_err` pulse, 3 pops with `dst_we`=0, then `pkt_done`; source 3 is served next.
- `rst` asserted during XFER of source 1 → next cycle all outputs 0; after release, a request from sources 0 and 1 grants 0.
- With `USB_TX_HDR_EN`, a source 3 packet → first word 0xC300, then the payload.

Source files
------------

// File: rtl/usb_tx_arbiter_if.sv
// Handshake bundle between the packet sources, the tx arbiter and the EP6 FIFO write port.
// master = arbiter side, slave = sources/FIFO side.
interface usb_tx_arbiter_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0]    src_req;
  logic [N_SRC-1:0]    src_empty;
  logic [16*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]    src_last;
  logic [N_SRC-1:0]    src_re;
  logic [15:0]         dst_data;
  logic                dst_we;
  logic                dst_full;
  logic [N_SRC-1:0]    grant;
  logic                busy;
  logic                pkt_done;
  logic                trunc_err;

  modport master (
    input  src_req, src_empty, src_data, src_last, dst_full,
    output src_re, dst_data, dst_we, grant, busy, pkt_done, trunc_err
  );

  modport slave (
    output src_req, src_empty, src_data, src_last, dst_full,
    input  src_re, dst_data, dst_we, grant, busy, pkt_done, trunc_err
  );
endinterface

// File: rtl/usb_tx_arbiter.sv
// Round-robin whole-packet arbiter feeding the EP6 FIFO; over-length packets are drained.
// Optional header word per packet when USB_TX_HDR_EN is defined.
module usb_tx_arbiter #(
  parameter int N_SRC     = 4,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  usb_tx_arbiter_if.master  bus
);
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CW = $clog2(MAX_WORDS) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WORDS);

  typedef enum logic [2:0] {IDLE, HDR, XFER, DRAIN, GAP} state_t;

  state_t           state_reg, state_next;
  logic [N_SRC-1:0] grant_reg, grant_next;
  logic [IW-1:0]    gidx_reg, gidx_next;
  logic [IW-1:0]    last_grant_reg, last_grant_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             busy_reg, pkt_done_reg, trunc_err_reg;
  logic             trunc_next;

  logic             pop, we;
  logic [15:0]      data_out;

  logic [15:0]      src_word [N_SRC];
  logic             head_empty, head_last;
  logic [15:0]      head_data;

  logic             req_found;
  logic [IW-1:0]    req_idx, cand;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign src_word[gi]   = bus.src_data[16*gi +: 16];
      // Pops only ever reach the owner because grant_reg is one-hot.
      assign bus.src_re[gi] = pop && grant_reg[gi];
    end
  endgenerate

  assign head_empty = bus.src_empty[gidx_reg];
  assign head_last  = bus.src_last[gidx_reg];
  assign head_data  = src_word[gidx_reg];

  // First requester searching upward from last_grant+1, wrapping at N_SRC.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = IW'((int'(last_grant_reg) + k) % N_SRC);
      if (!req_found && bus.src_req[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    gidx_next       = gidx_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    trunc_next      = 1'b0;
    pop             = 1'b0;
    we              = 1'b0;
    data_out        = '0;
    case (state_reg)
      IDLE: begin
        if (req_found) begin
          grant_next = N_SRC'(1) << req_idx;
          gidx_next  = req_idx;
          cnt_next   = '0;
`ifdef USB_TX_HDR_EN
          state_next = HDR;
`else
          state_next = XFER;
`endif
        end
      end
`ifdef USB_TX_HDR_EN
      HDR: begin
        if (!bus.dst_full) begin
          we         = 1'b1;
          data_out   = {4'hC, 4'(gidx_reg), 8'h00};
          state_next = XFER;
        end
      end
`endif
      XFER: begin
        if (!bus.dst_full && !head_empty) begin
          pop      = 1'b1;
          we       = 1'b1;
          data_out = head_data;
          cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);
          if (head_last) begin
            state_next = GAP;
          end else if (cnt_next == CNT_MAX) begin
            state_next = DRAIN;
            trunc_next = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Downstream fullness is irrelevant: nothing is written here.
        if (!head_empty) begin
          pop = 1'b1;
          if (head_last) state_next = GAP;
        end
      end
      GAP: begin
        last_grant_next = gidx_reg;
        grant_next      = '0;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      gidx_reg       <= '0;
      last_grant_reg <= IW'(N_SRC - 1);
      cnt_reg        <= '0;
      busy_reg       <= 1'b0;
      pkt_done_reg   <= 1'b0;
      trunc_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      gidx_reg       <= gidx_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      busy_reg       <= (state_next == HDR) || (state_next == XFER) || (state_next == DRAIN);
      pkt_done_reg   <= (state_next == GAP);
      trunc_err_reg  <= trunc_next;
    end
  end

  assign bus.dst_we    = we;
  assign bus.dst_data  = data_out;
  assign bus.grant     = grant_reg;
  assign bus.busy      = busy_reg;
  assign bus.pkt_done  = pkt_done_reg;
  assign bus.trunc_err = trunc_err_reg;
endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Scoreboard bench for usb_tx_arbiter: FWFT source queues, expected-word queue, per-scenario tasks.
module tb_usb_tx_arbiter;
  localparam int N    = 4;
  localparam int MAXW = 8;
`ifdef USB_TX_HDR_EN
  localparam int HDRW = 1;
`else
  localparam int HDRW = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  usb_tx_arbiter_if #(.N_SRC(N)) bus();

  usb_tx_arbiter #(.N_SRC(N), .MAX_WORDS(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          src;
    bit          mark;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  logic [15:0] sq_data [N][$];
  bit          sq_last [N][$];
  logic [N-1:0] pend_pop;
  logic [N-1:0] mon_oh;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int drain_pops = 0;
  int mark_cyc [$];
  int done_cyc [$];
  int trunc_cyc [$];
  int wr_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      bit r;
      r = 1'b0;
      for (int k = 0; k < sq_last[i].size(); k++) if (sq_last[i][k]) r = 1'b1;
      bus.src_req[i]         = r;
      bus.src_empty[i]       = (sq_data[i].size() == 0);
      bus.src_data[16*i +: 16] = (sq_data[i].size() != 0) ? sq_data[i][0] : 16'h0000;
      bus.src_last[i]        = (sq_last[i].size() != 0) ? sq_last[i][0] : 1'b0;
    end
  endtask

  // Source model: apply pops seen in the previous cycle, then present new heads.
  initial begin
    drive_srcs();
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (pend_pop[i] && sq_data[i].size() > 0) begin
          void'(sq_data[i].pop_front());
          void'(sq_last[i].pop_front());
        end
      end
      #1;
      drive_srcs();
    end
  end

  // Monitor: inputs only change just after posedge, so negedge values are what the edge commits.
  initial begin
    pend_pop = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_pop = '0;
      end else begin
        pend_pop = bus.src_re;
        if (bus.src_re != '0 && !bus.dst_we) drain_pops++;
        if (bus.pkt_done) done_cyc.push_back(cyc);
        if (bus.trunc_err) trunc_cyc.push_back(cyc);
        if (bus.dst_we) begin
          wr_cnt++;
          wr_cyc.push_back(cyc);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write cyc=%0d got=%h grant=%b expected=none", cyc, bus.dst_data, bus.grant);
          end else begin
            mon_e  = exp_q.pop_front();
            mon_oh = N'(1) << mon_e.src;
            if (bus.dst_data !== mon_e.data || bus.grant !== mon_oh || (bus.src_re & ~bus.grant) != '0) begin
              failures++;
              $display("FAIL write cyc=%0d got data=%h grant=%b re=%b want data=%h grant=%b",
                       cyc, bus.dst_data, bus.grant, bus.src_re, mon_e.data, mon_oh);
            end else begin
              $display("write cyc=%0d src=%0d data=%h", cyc, mon_e.src, bus.dst_data);
            end
            if (mon_e.mark) mark_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_src(int s, int n, logic [15:0] base, logic [15:0] stp);
    for (int k = 0; k < n; k++) begin
      sq_data[s].push_back(base + 16'(k) * stp);
      sq_last[s].push_back(k == n - 1);
    end
  endtask

  task automatic push_exp(int s, int n, logic [15:0] base, logic [15:0] stp);
    exp_t e;
    int m;
`ifdef USB_TX_HDR_EN
    e.data = {4'hC, 4'(s), 8'h00};
    e.src  = s;
    e.mark = 1'b0;
    exp_q.push_back(e);
`endif
    m = (n > MAXW) ? MAXW : n;
    for (int k = 0; k < m; k++) begin
      e.data = base + 16'(k) * stp;
      e.src  = s;
      e.mark = (k == m - 1);
      exp_q.push_back(e);
    end
  endtask

  function automatic int src_total();
    int t;
    t = 0;
    for (int i = 0; i < N; i++) t += sq_data[i].size();
    return t;
  endfunction

  task automatic wait_done(string name);
    int c;
    c = 0;
    while (!(exp_q.size() == 0 && src_total() == 0 && !bus.busy && !bus.pkt_done) && c < 400) begin
      step();
      c++;
    end
    checks++;
    if (c >= 400) begin
      failures++;
      $display("FAIL %s_timeout pending_exp=%0d pending_src=%0d want both 0", name, exp_q.size(), src_total());
    end
    step();
  endtask

  task automatic wait_writes(int target, string name);
    int c;
    c = 0;
    while (wr_cnt < target && c < 200) begin
      step();
      c++;
    end
    if (c >= 200) begin
      checks++;
      failures++;
      $display("FAIL %s_wait writes=%0d want=%0d", name, wr_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.pkt_done !== 1'b0 || bus.trunc_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs got grant=%b busy=%b done=%b trunc=%b want all 0",
               bus.grant, bus.busy, bus.pkt_done, bus.trunc_err);
    end
    checks++;
    if (bus.src_re !== '0 || bus.dst_we !== 1'b0 || bus.dst_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_comb got re=%b we=%b data=%h want 0", bus.src_re, bus.dst_we, bus.dst_data);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.grant !== '0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got grant=%b busy=%b want 0", bus.grant, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    int d0;
    d0 = done_cyc.size();
    push_src(0, 2, 16'h0A00, 16'h0001);
    push_src(0, 2, 16'h0A10, 16'h0001);
    for (int s = 1; s < N; s++) push_src(s, 2, 16'h0A00 + 16'(s) * 16'h0100, 16'h0001);
    push_exp(0, 2, 16'h0A00, 16'h0001);
    for (int s = 1; s < N; s++) push_exp(s, 2, 16'h0A00 + 16'(s) * 16'h0100, 16'h0001);
    push_exp(0, 2, 16'h0A10, 16'h0001);
    wait_done("round_robin");
    checks++;
    if (done_cyc.size() - d0 != 5) begin
      failures++;
      $display("FAIL rr_pkt_done_count got=%0d want=5", done_cyc.size() - d0);
    end
  endtask

  task automatic test_single();
    int d0, w0;
    d0 = done_cyc.size();
    w0 = wr_cyc.size();
    push_src(0, 3, 16'h1111, 16'h1111);
    push_exp(0, 3, 16'h1111, 16'h1111);
    wait_done("single");
    checks++;
    if (wr_cyc.size() - w0 != 3 + HDRW) begin
      failures++;
      $display("FAIL single_write_count got=%0d want=%0d", wr_cyc.size() - w0, 3 + HDRW);
    end else begin
      checks++;
      if (wr_cyc[wr_cyc.size()-1] - wr_cyc[wr_cyc.size()-3] != 2) begin
        failures++;
        $display("FAIL single_consecutive got span=%0d want=2", wr_cyc[wr_cyc.size()-1] - wr_cyc[wr_cyc.size()-3]);
      end
    end
    checks++;
    if (done_cyc.size() - d0 != 1) begin
      failures++;
      $display("FAIL single_done_count got=%0d want=1", done_cyc.size() - d0);
    end else begin
      checks++;
      if (done_cyc[d0] != mark_cyc[mark_cyc.size()-1] + 1) begin
        failures++;
        $display("FAIL single_done_timing got cyc=%0d want=%0d", done_cyc[d0], mark_cyc[mark_cyc.size()-1] + 1);
      end
    end
  endtask

  task automatic test_dst_full();
    int start;
    start = wr_cnt;
    push_src(1, 6, 16'h6001, 16'h0001);
    push_exp(1, 6, 16'h6001, 16'h0001);
    wait_writes(start + HDRW + 2, "full");
    bus.dst_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.src_re !== '0 || bus.dst_we !== 1'b0) begin
        failures++;
        $display("FAIL full_blocks cycle=%0d got re=%b we=%b want 0", k, bus.src_re, bus.dst_we);
      end
      step();
    end
    bus.dst_full = 1'b0;
    wait_done("full");
    checks++;
    if (wr_cnt - start != 6 + HDRW) begin
      failures++;
      $display("FAIL full_word_count got=%0d want=%0d", wr_cnt - start, 6 + HDRW);
    end
  endtask

  task automatic test_trunc();
    int t0, m0, d0, p0;
    t0 = trunc_cyc.size();
    m0 = mark_cyc.size();
    d0 = done_cyc.size();
    p0 = drain_pops;
    push_src(2, 11, 16'h2001, 16'h0001);
    push_src(3, 2, 16'h3001, 16'h0001);
    push_exp(2, 11, 16'h2001, 16'h0001);
    push_exp(3, 2, 16'h3001, 16'h0001);
    wait_done("trunc");
    checks++;
    if (trunc_cyc.size() - t0 != 1) begin
      failures++;
      $display("FAIL trunc_pulse_count got=%0d want=1", trunc_cyc.size() - t0);
    end else begin
      checks++;
      if (trunc_cyc[t0] != mark_cyc[m0] + 1) begin
        failures++;
        $display("FAIL trunc_timing got cyc=%0d want=%0d", trunc_cyc[t0], mark_cyc[m0] + 1);
      end
    end
    checks++;
    if (drain_pops - p0 != 3) begin
      failures++;
      $display("FAIL drain_pops got=%0d want=3", drain_pops - p0);
    end
    checks++;
    if (done_cyc.size() - d0 != 2 || mark_cyc.size() - m0 != 2) begin
      failures++;
      $display("FAIL trunc_done_count got=%0d want=2", done_cyc.size() - d0);
    end else begin
      checks++;
      if (done_cyc[d0] != mark_cyc[m0] + 4) begin
        failures++;
        $display("FAIL trunc_done_timing got cyc=%0d want=%0d", done_cyc[d0], mark_cyc[m0] + 4);
      end
    end
  endtask

  task automatic test_reset_mid();
    int start, c;
    start = wr_cnt;
    push_src(1, 6, 16'h7001, 16'h0001);
    push_exp(1, 6, 16'h7001, 16'h0001);
    wait_writes(start + HDRW + 2, "rst_mid");
    rst = 1'b1;
    step();
    checks++;
    if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.pkt_done !== 1'b0 || bus.trunc_err !== 1'b0 ||
        bus.src_re !== '0 || bus.dst_we !== 1'b0 || bus.dst_data !== 16'h0000) begin
      failures++;
      $display("FAIL rst_mid_outputs got grant=%b busy=%b done=%b trunc=%b re=%b we=%b data=%h want all 0",
               bus.grant, bus.busy, bus.pkt_done, bus.trunc_err, bus.src_re, bus.dst_we, bus.dst_data);
    end
    for (int i = 0; i < N; i++) begin
      sq_data[i].delete();
      sq_last[i].delete();
    end
    exp_q.delete();
    step();
    rst = 1'b0;
    push_src(0, 2, 16'h8001, 16'h0001);
    push_src(1, 2, 16'h8101, 16'h0001);
    push_exp(0, 2, 16'h8001, 16'h0001);
    push_exp(1, 2, 16'h8101, 16'h0001);
    c = 0;
    while (bus.grant == '0 && c < 20) begin
      step();
      c++;
    end
    checks++;
    if (bus.grant !== 4'b0001) begin
      failures++;
      $display("FAIL rst_mid_first_grant got=%b want=0001", bus.grant);
    end
    wait_done("rst_mid");
  endtask

  task automatic test_src3();
    int start;
    start = wr_cnt;
    push_src(3, 3, 16'h3A01, 16'h0001);
    push_exp(3, 3, 16'h3A01, 16'h0001);
    wait_done("src3");
    checks++;
    if (wr_cnt - start != 3 + HDRW) begin
      failures++;
      $display("FAIL src3_word_count got=%0d want=%0d", wr_cnt - start, 3 + HDRW);
    end
  endtask

  initial begin
    bus.dst_full = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_dst_full();
    test_trunc();
    test_reset_mid();
    test_src3();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
